// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    RETURN = 2'd2
  } trap_state_e;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-stage, interrupt-source and CSR-block signals seen by the trap controller.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic              exc_valid;
  logic [XLEN-2:0]   exc_code;
  logic [XLEN-1:0]   exc_pc;
  logic [XLEN-1:0]   exc_tval;
  logic              mret_valid;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic              irq_msip_raw;
  logic              irq_mtip_raw;
  logic              irq_meip_raw;
  logic              csr_rd_mstatus_mie;
  logic              csr_rd_mstatus_mpie;
  logic              csr_rd_mie_msie;
  logic              csr_rd_mie_mtie;
  logic              csr_rd_mie_meie;
  logic [XLEN-3:0]   csr_rd_mtvec_base;
  logic [1:0]        csr_rd_mtvec_mode;
  logic [XLEN-1:0]   csr_rd_mepc_mepc;
  logic              ent_trap;
  logic              ext_trap;
  logic              csr_wr_mstatus_mie;
  logic              csr_wr_mstatus_mpie;
  logic [XLEN-1:0]   csr_wr_mepc_mepc;
  logic [XLEN-1:0]   csr_wr_mtval_mtval;
  logic [XLEN-2:0]   csr_wr_mcause_exception_code;
  logic              csr_wr_mcause_interrupt;
  logic              csr_set_mip_msip;
  logic              csr_set_mip_mtip;
  logic              csr_set_mip_meip;
  logic              exc_ack;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              flush;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, mret_valid, commit_valid, commit_pc,
           irq_msip_raw, irq_mtip_raw, irq_meip_raw,
           csr_rd_mstatus_mie, csr_rd_mstatus_mpie, csr_rd_mie_msie, csr_rd_mie_mtie,
           csr_rd_mie_meie, csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
    input  ent_trap, ext_trap, csr_wr_mstatus_mie, csr_wr_mstatus_mpie, csr_wr_mepc_mepc,
           csr_wr_mtval_mtval, csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
           csr_set_mip_msip, csr_set_mip_mtip, csr_set_mip_meip, exc_ack,
           redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, mret_valid, commit_valid, commit_pc,
           irq_msip_raw, irq_mtip_raw, irq_meip_raw,
           csr_rd_mstatus_mie, csr_rd_mstatus_mpie, csr_rd_mie_msie, csr_rd_mie_mtie,
           csr_rd_mie_meie, csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
    output ent_trap, ext_trap, csr_wr_mstatus_mie, csr_wr_mstatus_mpie, csr_wr_mepc_mepc,
           csr_wr_mtval_mtval, csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
           csr_set_mip_msip, csr_set_mip_mtip, csr_set_mip_meip, exc_ack,
           redirect_valid, redirect_pc, flush
  );

endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// N-flop synchronizer for one asynchronous interrupt line, plus a one-cycle
// pulse on each rising edge of the synchronized level.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              edge_reg;
  logic              rise_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg[0] <= raw;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      edge_reg <= sync_reg[STAGES-1];
      rise_reg <= sync_reg[STAGES-1] & ~edge_reg;
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = rise_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, MRET and interrupts,
// drives the CSR hardware-write bus and issues a registered redirect + flush.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst_b,
  trap_ctrl_if.slave bus
);

  localparam logic [XLEN-2:0] CODE_MSI = (XLEN-1)'(IRQ_MSI);
  localparam logic [XLEN-2:0] CODE_MTI = (XLEN-1)'(IRQ_MTI);
  localparam logic [XLEN-2:0] CODE_MEI = (XLEN-1)'(IRQ_MEI);

  trap_state_e     state_reg, state_next;
  logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;

  // Bit order for the per-source vectors: 0 = MSI, 1 = MTI, 2 = MEI.
  logic [2:0] raw_vec, level_vec, rise_vec;

  assign raw_vec = {bus.irq_meip_raw, bus.irq_mtip_raw, bus.irq_msip_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi])
      );
    end
  endgenerate

  assign bus.csr_set_mip_msip = rise_vec[0];
  assign bus.csr_set_mip_mtip = rise_vec[1];
  assign bus.csr_set_mip_meip = rise_vec[2];

  logic            pend_msi, pend_mti, pend_mei, irq_any;
  logic [XLEN-2:0] irq_code;
  logic [XLEN-1:0] trap_base, vec_offset;

  assign pend_msi = level_vec[0] & bus.csr_rd_mie_msie & bus.csr_rd_mstatus_mie;
  assign pend_mti = level_vec[1] & bus.csr_rd_mie_mtie & bus.csr_rd_mstatus_mie;
  assign pend_mei = level_vec[2] & bus.csr_rd_mie_meie & bus.csr_rd_mstatus_mie;
  assign irq_any  = pend_msi | pend_mti | pend_mei;
  assign irq_code = pend_mei ? CODE_MEI : (pend_msi ? CODE_MSI : CODE_MTI);

  assign trap_base = {bus.csr_rd_mtvec_base, 2'b00};

  // Reserved modes fall back to direct.
  always_comb begin
    vec_offset = '0;
    case (bus.csr_rd_mtvec_mode)
      MTVEC_DIRECT:   vec_offset = '0;
      MTVEC_VECTORED: vec_offset = {irq_code[XLEN-3:0], 2'b00};
      default:        vec_offset = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg       <= IDLE;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  // The redirect target is fully resolved in the accept cycle and held for the
  // following ENTER/RETURN cycle.
  always_comb begin
    state_next                       = state_reg;
    redirect_pc_next                 = redirect_pc_reg;
    bus.ent_trap                     = 1'b0;
    bus.ext_trap                     = 1'b0;
    bus.exc_ack                      = 1'b0;
    bus.csr_wr_mstatus_mie           = 1'b0;
    bus.csr_wr_mstatus_mpie          = 1'b0;
    bus.csr_wr_mepc_mepc             = '0;
    bus.csr_wr_mtval_mtval           = '0;
    bus.csr_wr_mcause_exception_code = '0;
    bus.csr_wr_mcause_interrupt      = 1'b0;
    bus.redirect_valid               = 1'b0;
    bus.redirect_pc                  = '0;
    bus.flush                        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.exc_valid) begin
          bus.ent_trap                     = 1'b1;
          bus.exc_ack                      = 1'b1;
          bus.csr_wr_mepc_mepc             = bus.exc_pc;
          bus.csr_wr_mtval_mtval           = bus.exc_tval;
          bus.csr_wr_mcause_exception_code = bus.exc_code;
          bus.csr_wr_mstatus_mpie          = bus.csr_rd_mstatus_mie;
          redirect_pc_next                 = trap_base;
          state_next                       = ENTER;
        end else if (bus.mret_valid) begin
          bus.ext_trap            = 1'b1;
          bus.exc_ack             = 1'b1;
          bus.csr_wr_mstatus_mie  = bus.csr_rd_mstatus_mpie;
          bus.csr_wr_mstatus_mpie = 1'b1;
          redirect_pc_next        = bus.csr_rd_mepc_mepc;
          state_next              = RETURN;
        end else if (bus.commit_valid && irq_any) begin
          bus.ent_trap                     = 1'b1;
          bus.csr_wr_mepc_mepc             = bus.commit_pc;
          bus.csr_wr_mcause_exception_code = irq_code;
          bus.csr_wr_mcause_interrupt      = 1'b1;
          bus.csr_wr_mstatus_mpie          = bus.csr_rd_mstatus_mie;
          redirect_pc_next                 = trap_base + vec_offset;
          state_next                       = ENTER;
        end
      end
      ENTER, RETURN: begin
        bus.redirect_valid = 1'b1;
        bus.flush          = 1'b1;
        bus.redirect_pc    = redirect_pc_reg;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand-written
// interrupt/reset sequences and a randomized run against a reference model.
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        ent, ext, ack, cint, mie_wr, mpie_wr, rv, fl, s_ms, s_mt, s_me;
    logic [31:0] mepc, mtval, code, rpc;
  } out_t;

  typedef struct packed {
    logic        exc;
    logic [30:0] code;
    logic [31:0] pc, tval;
    logic        mret, mie, mpie;
    logic [31:0] mtvec, mepc;
    out_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic out_t sample_dut();
    out_t o;
    o.ent     = bus.ent_trap;
    o.ext     = bus.ext_trap;
    o.ack     = bus.exc_ack;
    o.cint    = bus.csr_wr_mcause_interrupt;
    o.mie_wr  = bus.csr_wr_mstatus_mie;
    o.mpie_wr = bus.csr_wr_mstatus_mpie;
    o.rv      = bus.redirect_valid;
    o.fl      = bus.flush;
    o.s_ms    = bus.csr_set_mip_msip;
    o.s_mt    = bus.csr_set_mip_mtip;
    o.s_me    = bus.csr_set_mip_meip;
    o.mepc    = bus.csr_wr_mepc_mepc;
    o.mtval   = bus.csr_wr_mtval_mtval;
    o.code    = {1'b0, bus.csr_wr_mcause_exception_code};
    o.rpc     = bus.redirect_pc;
    return o;
  endfunction

  task automatic compare_out(input string tag, input out_t e, input bit chk_rpc);
    out_t a;
    a = sample_dut();
    chk({tag, " ent_trap"},  32'(a.ent),     32'(e.ent));
    chk({tag, " ext_trap"},  32'(a.ext),     32'(e.ext));
    chk({tag, " exc_ack"},   32'(a.ack),     32'(e.ack));
    chk({tag, " mcause_int"},32'(a.cint),    32'(e.cint));
    chk({tag, " mie_wr"},    32'(a.mie_wr),  32'(e.mie_wr));
    chk({tag, " mpie_wr"},   32'(a.mpie_wr), 32'(e.mpie_wr));
    chk({tag, " redir_vld"}, 32'(a.rv),      32'(e.rv));
    chk({tag, " flush"},     32'(a.fl),      32'(e.fl));
    chk({tag, " set_msip"},  32'(a.s_ms),    32'(e.s_ms));
    chk({tag, " set_mtip"},  32'(a.s_mt),    32'(e.s_mt));
    chk({tag, " set_meip"},  32'(a.s_me),    32'(e.s_me));
    chk({tag, " mepc_wr"},   a.mepc,         e.mepc);
    chk({tag, " mtval_wr"},  a.mtval,        e.mtval);
    chk({tag, " code_wr"},   a.code,         e.code);
    if (chk_rpc) chk({tag, " redir_pc"}, a.rpc, e.rpc);
  endtask

  task automatic clear_inputs();
    bus.exc_valid = 0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_tval = '0;
    bus.mret_valid = 0; bus.commit_valid = 0; bus.commit_pc = '0;
    bus.irq_msip_raw = 0; bus.irq_mtip_raw = 0; bus.irq_meip_raw = 0;
    bus.csr_rd_mstatus_mie = 0; bus.csr_rd_mstatus_mpie = 0;
    bus.csr_rd_mie_msie = 0; bus.csr_rd_mie_mtie = 0; bus.csr_rd_mie_meie = 0;
    bus.csr_rd_mtvec_base = '0; bus.csr_rd_mtvec_mode = '0; bus.csr_rd_mepc_mepc = '0;
  endtask

  task automatic set_mtvec(input logic [31:0] v);
    bus.csr_rd_mtvec_base = v[31:2];
    bus.csr_rd_mtvec_mode = v[1:0];
  endtask

  function automatic vec_t mk_vec(input logic exc, input logic [30:0] code, input logic [31:0] pc,
                                  input logic [31:0] tval, input logic mret, input logic mie,
                                  input logic mpie, input logic [31:0] mtvec, input logic [31:0] mepc,
                                  input logic ent, input logic ext, input logic [31:0] wcode,
                                  input logic [31:0] wmepc, input logic [31:0] wmtval,
                                  input logic wmie, input logic wmpie, input logic [31:0] rpc);
    vec_t v;
    v = '0;
    v.exc = exc; v.code = code; v.pc = pc; v.tval = tval; v.mret = mret;
    v.mie = mie; v.mpie = mpie; v.mtvec = mtvec; v.mepc = mepc;
    v.exp.ent = ent; v.exp.ext = ext; v.exp.ack = 1'b1;
    v.exp.code = wcode; v.exp.mepc = wmepc; v.exp.mtval = wmtval;
    v.exp.mie_wr = wmie; v.exp.mpie_wr = wmpie; v.exp.rpc = rpc;
    return v;
  endfunction

  // Reference model state for the randomized phase.
  logic [SYNC+1:0] h_ms = '0, h_mt = '0, h_me = '0;  // bit k: raw level sampled k edges ago
  bit              m_busy = 0, m_acc = 0;
  logic [31:0]     m_pc = '0, m_acc_pc = '0;

  task automatic model_expect(output out_t e);
    logic        pm, ps, pt;
    logic [31:0] base;
    int          id;
    e = '0;
    m_acc = 0;
    e.s_ms = h_ms[SYNC] & ~h_ms[SYNC+1];
    e.s_mt = h_mt[SYNC] & ~h_mt[SYNC+1];
    e.s_me = h_me[SYNC] & ~h_me[SYNC+1];
    pm = h_me[SYNC-1] & bus.csr_rd_mie_meie & bus.csr_rd_mstatus_mie;
    ps = h_ms[SYNC-1] & bus.csr_rd_mie_msie & bus.csr_rd_mstatus_mie;
    pt = h_mt[SYNC-1] & bus.csr_rd_mie_mtie & bus.csr_rd_mstatus_mie;
    base = {bus.csr_rd_mtvec_base, 2'b00};
    if (m_busy) begin
      e.rv = 1; e.fl = 1; e.rpc = m_pc;
    end else if (bus.exc_valid) begin
      e.ent = 1; e.ack = 1; e.mepc = bus.exc_pc; e.mtval = bus.exc_tval;
      e.code = {1'b0, bus.exc_code}; e.mpie_wr = bus.csr_rd_mstatus_mie;
      m_acc = 1; m_acc_pc = base;
    end else if (bus.mret_valid) begin
      e.ext = 1; e.ack = 1; e.mie_wr = bus.csr_rd_mstatus_mpie; e.mpie_wr = 1;
      m_acc = 1; m_acc_pc = bus.csr_rd_mepc_mepc;
    end else if (bus.commit_valid && (pm || ps || pt)) begin
      id = pm ? 11 : (ps ? 3 : 7);
      e.ent = 1; e.cint = 1; e.mepc = bus.commit_pc; e.code = 32'(id);
      e.mpie_wr = bus.csr_rd_mstatus_mie;
      m_acc = 1;
      m_acc_pc = (bus.csr_rd_mtvec_mode == 2'd1) ? base + 32'(4 * id) : base;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    out_t e;
    int   ent_cyc, rd_cyc, pulse_cyc, pulse_cnt, ent_cnt;
    bit   drop_commit;

    vecs[0] = mk_vec(1, 31'd2, 32'h100, 32'hDEAD, 0, 1, 0, 32'h8000_0000, 32'h0,
                     1, 0, 32'd2, 32'h100, 32'hDEAD, 0, 1, 32'h8000_0000);
    vecs[1] = mk_vec(0, 31'd0, 32'h0, 32'h0, 1, 0, 1, 32'h8000_0000, 32'h300,
                     0, 1, 32'd0, 32'h0, 32'h0, 1, 1, 32'h300);
    vecs[2] = mk_vec(1, 31'd5, 32'h400, 32'h44, 1, 0, 1, 32'h1000_0001, 32'h999,
                     1, 0, 32'd5, 32'h400, 32'h44, 0, 0, 32'h1000_0000);
    vecs[3] = mk_vec(1, 31'd13, 32'hFFFF_FFFC, 32'h0, 0, 1, 1, 32'h0000_2002, 32'h0,
                     1, 0, 32'd13, 32'hFFFF_FFFC, 32'h0, 0, 1, 32'h0000_2000);
    vecs[4] = mk_vec(0, 31'd0, 32'h0, 32'h0, 1, 1, 0, 32'h0000_0003, 32'h1234_5678,
                     0, 1, 32'd0, 32'h0, 32'h0, 0, 1, 32'h1234_5678);

    clear_inputs();
    rst_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = '0;
    compare_out("reset", e, 1);
    rst_b = 1;
    repeat (2) @(posedge clk);

    // Directed accept / redirect table
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.exc_valid = vecs[i].exc; bus.exc_code = vecs[i].code;
      bus.exc_pc = vecs[i].pc; bus.exc_tval = vecs[i].tval;
      bus.mret_valid = vecs[i].mret;
      bus.csr_rd_mstatus_mie = vecs[i].mie; bus.csr_rd_mstatus_mpie = vecs[i].mpie;
      set_mtvec(vecs[i].mtvec); bus.csr_rd_mepc_mepc = vecs[i].mepc;
      @(negedge clk);
      compare_out($sformatf("vec%0d accept", i), vecs[i].exp, 0);
      @(posedge clk); #1;
      bus.exc_valid = 0; bus.mret_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d redir_vld", i), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("vec%0d flush", i), 32'(bus.flush), 32'd1);
      chk($sformatf("vec%0d redir_pc", i), bus.redirect_pc, vecs[i].exp.rpc);
      chk($sformatf("vec%0d no_ent_in_redir", i), 32'(bus.ent_trap | bus.ext_trap), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d idle_after", i), 32'(bus.redirect_valid), 32'd0);
      $display("vec %0d: exc=%0b mret=%0b -> redirect 0x%08h", i, vecs[i].exc, vecs[i].mret,
               vecs[i].exp.rpc);
    end

    // Vectored timer interrupt
    clear_inputs();
    @(posedge clk); #1;
    set_mtvec(32'h8000_0001);
    bus.csr_rd_mstatus_mie = 1; bus.csr_rd_mie_mtie = 1;
    bus.commit_valid = 1; bus.commit_pc = 32'h200; bus.irq_mtip_raw = 1;
    ent_cyc = -1; rd_cyc = -1; pulse_cyc = -1; pulse_cnt = 0; drop_commit = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      if (drop_commit) begin #1; bus.commit_valid = 0; drop_commit = 0; end
      @(negedge clk);
      if (bus.ent_trap && ent_cyc < 0) begin
        ent_cyc = k; drop_commit = 1;
        chk("mti mcause_int", 32'(bus.csr_wr_mcause_interrupt), 32'd1);
        chk("mti code", {1'b0, bus.csr_wr_mcause_exception_code}, 32'd7);
        chk("mti mepc", bus.csr_wr_mepc_mepc, 32'h200);
        chk("mti mtval", bus.csr_wr_mtval_mtval, 32'h0);
      end
      if (bus.redirect_valid && rd_cyc < 0) begin
        rd_cyc = k;
        chk("mti redir_pc", bus.redirect_pc, 32'h8000_001C);
      end
      if (bus.csr_set_mip_mtip) begin
        pulse_cnt++;
        if (pulse_cyc < 0) pulse_cyc = k;
      end
    end
    chk("mti ent_cycle", 32'(ent_cyc), 32'd2);
    chk("mti redir_cycle", 32'(rd_cyc), 32'd3);
    chk("mti pulse_cycle", 32'(pulse_cyc), 32'd3);
    chk("mti pulse_count", 32'(pulse_cnt), 32'd1);
    $display("seq vectored timer irq: ent@%0d redirect@%0d mip_pulse@%0d", ent_cyc, rd_cyc, pulse_cyc);

    // Priority: exception beats interrupts, then MEI wins among interrupts
    clear_inputs();
    @(posedge clk); #1;
    set_mtvec(32'h0000_4000);
    bus.csr_rd_mstatus_mie = 1;
    bus.csr_rd_mie_msie = 1; bus.csr_rd_mie_mtie = 1; bus.csr_rd_mie_meie = 1;
    bus.irq_msip_raw = 1; bus.irq_mtip_raw = 1; bus.irq_meip_raw = 1;
    repeat (5) @(posedge clk);
    #1;
    bus.exc_valid = 1; bus.exc_code = 31'd11; bus.exc_pc = 32'h600;
    bus.commit_valid = 1; bus.commit_pc = 32'h500;
    @(negedge clk);
    chk("prio exc ent", 32'(bus.ent_trap), 32'd1);
    chk("prio exc ack", 32'(bus.exc_ack), 32'd1);
    chk("prio exc mcause_int", 32'(bus.csr_wr_mcause_interrupt), 32'd0);
    chk("prio exc code", {1'b0, bus.csr_wr_mcause_exception_code}, 32'd11);
    chk("prio exc mepc", bus.csr_wr_mepc_mepc, 32'h600);
    @(posedge clk); #1;
    bus.exc_valid = 0;
    @(negedge clk);
    chk("prio redir_vld", 32'(bus.redirect_valid), 32'd1);
    chk("prio no_ent_in_enter", 32'(bus.ent_trap), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("prio irq ent", 32'(bus.ent_trap), 32'd1);
    chk("prio irq ack", 32'(bus.exc_ack), 32'd0);
    chk("prio irq mcause_int", 32'(bus.csr_wr_mcause_interrupt), 32'd1);
    chk("prio irq code", {1'b0, bus.csr_wr_mcause_exception_code}, 32'd11);
    chk("prio irq mepc", bus.csr_wr_mepc_mepc, 32'h500);
    @(posedge clk); #1;
    clear_inputs();
    repeat (5) @(posedge clk);
    $display("seq priority: exception then MEI interrupt");

    // Masking: MEI level with global MIE off sets mip once but never traps
    #1;
    bus.csr_rd_mie_meie = 1; bus.commit_valid = 1; bus.irq_meip_raw = 1;
    ent_cnt = 0; pulse_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.ent_trap) ent_cnt++;
      if (bus.csr_set_mip_meip) pulse_cnt++;
    end
    chk("mask ent_count", 32'(ent_cnt), 32'd0);
    chk("mask meip_pulses", 32'(pulse_cnt), 32'd1);
    @(posedge clk); #1;
    clear_inputs();
    repeat (5) @(posedge clk);
    $display("seq masking: ent=%0d meip_pulses=%0d", ent_cnt, pulse_cnt);

    // Reset asserted while in ENTER
    #1;
    bus.exc_valid = 1; bus.exc_code = 31'd4; bus.exc_pc = 32'h700; set_mtvec(32'h0000_8000);
    @(posedge clk); #1;
    bus.exc_valid = 0;
    chk("rst pre redir_vld", 32'(bus.redirect_valid), 32'd1);
    #1;
    rst_b = 0;
    #1;
    chk("rst async redir_vld", 32'(bus.redirect_valid), 32'd0);
    chk("rst async flush", 32'(bus.flush), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1;
    rd_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.redirect_valid) rd_cyc++;
    end
    chk("rst no_redirect_after", 32'(rd_cyc), 32'd0);
    $display("seq reset mid-trap: redirects after release=%0d", rd_cyc);

    // Randomized run against the reference model
    clear_inputs();
    repeat (6) @(posedge clk);
    h_ms = '0; h_mt = '0; h_me = '0; m_busy = 0; m_acc = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (m_busy) m_busy = 0;
      else if (m_acc) begin m_busy = 1; m_pc = m_acc_pc; end
      h_ms = {h_ms[SYNC:0], bus.irq_msip_raw};
      h_mt = {h_mt[SYNC:0], bus.irq_mtip_raw};
      h_me = {h_me[SYNC:0], bus.irq_meip_raw};
      #1;
      bus.exc_valid = ($urandom_range(0, 5) == 0);
      bus.exc_code = 31'($urandom);
      bus.exc_pc = $urandom; bus.exc_tval = $urandom;
      bus.mret_valid = ($urandom_range(0, 5) == 0);
      bus.commit_valid = $urandom_range(0, 1);
      bus.commit_pc = $urandom;
      if ($urandom_range(0, 7) == 0) bus.irq_msip_raw = ~bus.irq_msip_raw;
      if ($urandom_range(0, 7) == 0) bus.irq_mtip_raw = ~bus.irq_mtip_raw;
      if ($urandom_range(0, 7) == 0) bus.irq_meip_raw = ~bus.irq_meip_raw;
      bus.csr_rd_mstatus_mie = ($urandom_range(0, 3) != 0);
      bus.csr_rd_mstatus_mpie = $urandom_range(0, 1);
      bus.csr_rd_mie_msie = ($urandom_range(0, 3) != 0);
      bus.csr_rd_mie_mtie = ($urandom_range(0, 3) != 0);
      bus.csr_rd_mie_meie = ($urandom_range(0, 3) != 0);
      set_mtvec($urandom);
      bus.csr_rd_mepc_mepc = $urandom;
      @(negedge clk);
      model_expect(e);
      compare_out($sformatf("rnd%0d", c), e, e.rv);
      if (e.ent || e.ext)
        $display("rnd %0d: %s cause=%0d int=%0b target=0x%08h", c, e.ent ? "trap" : "mret",
                 e.code, e.cint, m_acc_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
